// File: rtl/lcd_bus_arbiter.sv
// rtl/lcd_bus_arbiter.sv - shares the 8-bit write-only LCD bus between a pixel stream and a command port
// Pixels are buffered losslessly up to PIX_DEPTH; multi-byte commands hold the bus until cmd_last.
module lcd_bus_arbiter #(
  parameter int PIX_DEPTH = 4,
  parameter int WR_GAP    = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       pix_valid,
  input  logic [7:0] pix_data,
  input  logic       cmd_valid,
  input  logic [7:0] cmd_data,
  input  logic       cmd_cd,
  input  logic       cmd_last,
  output logic       cmd_ready,
  output logic [7:0] lcd_data,
  output logic       lcd_cd,
  output logic       lcd_write,
  output logic       pix_ovf,
  output logic       busy
);

  localparam int AW = $clog2(PIX_DEPTH);
  localparam int GW = $clog2(WR_GAP + 1);

  typedef enum logic {
    S_OPEN,
    S_LOCKED
  } state_e;

  state_e          state_q, state_d;
  logic [7:0]      fifo_mem_q [PIX_DEPTH];
  logic [AW-1:0]   rd_ptr_q, wr_ptr_q;
  logic [AW:0]     count_q;
  logic [GW-1:0]   gap_q, gap_d;
  logic [7:0]      data_q, data_d;
  logic            cd_q, cd_d;
  logic            wr_q, wr_d;
  logic            ovf_q;

  logic            eligible;
  logic            fifo_empty;
  logic            fifo_full;
  logic            grant_pix;
  logic            grant_cmd;
  logic            push;
  logic            drop;

  assign fifo_empty = (count_q == '0);
  assign fifo_full  = (count_q == (AW+1)'(PIX_DEPTH));

  // The gap counter is frozen during the strobe cycle, so gap_cnt==1 marks the
  // last low cycle and a grant there keeps strobes exactly WR_GAP+1 apart.
  assign eligible = !wr_q && (gap_q <= GW'(1));

  always_comb begin
    state_d   = state_q;
    gap_d     = (gap_q != '0 && !wr_q) ? gap_q - GW'(1) : gap_q;
    data_d    = data_q;
    cd_d      = cd_q;
    wr_d      = 1'b0;
    grant_pix = 1'b0;
    grant_cmd = 1'b0;

    if (eligible) begin
      if (state_q == S_LOCKED) begin
        grant_cmd = cmd_valid;
      end else if (!fifo_empty) begin
        grant_pix = 1'b1;
      end else begin
        grant_cmd = cmd_valid;
      end
    end

    if (grant_pix) begin
      data_d = fifo_mem_q[rd_ptr_q];
      cd_d   = 1'b1;
      wr_d   = 1'b1;
      gap_d  = GW'(WR_GAP);
    end

    if (grant_cmd) begin
      data_d  = cmd_data;
      cd_d    = cmd_cd;
      wr_d    = 1'b1;
      gap_d   = GW'(WR_GAP);
      state_d = cmd_last ? S_OPEN : S_LOCKED;
    end
  end

  // A pop in the same cycle frees the slot, so a full FIFO can still accept.
  assign push = pix_valid && (!fifo_full || grant_pix);
  assign drop = pix_valid && fifo_full && !grant_pix;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_OPEN;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      gap_q    <= '0;
      data_q   <= '0;
      cd_q     <= 1'b0;
      wr_q     <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      gap_q   <= gap_d;
      data_q  <= data_d;
      cd_q    <= cd_d;
      wr_q    <= wr_d;
      ovf_q   <= ovf_q | drop;
      if (push) begin
        wr_ptr_q <= wr_ptr_q + AW'(1);
      end
      if (grant_pix) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
      end
      case ({push, grant_pix})
        2'b10:   count_q <= count_q + (AW+1)'(1);
        2'b01:   count_q <= count_q - (AW+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem_q[wr_ptr_q] <= pix_data;
    end
  end

  assign cmd_ready = grant_cmd && !reset;
  assign lcd_data  = data_q;
  assign lcd_cd    = cd_q;
  assign lcd_write = wr_q;
  assign pix_ovf   = ovf_q;
  assign busy      = !fifo_empty || (state_q == S_LOCKED) || wr_q || (gap_q != '0);

endmodule

// File: tb/tb_lcd_bus_arbiter.sv
// tb/tb_lcd_bus_arbiter.sv - directed scoreboard bench for lcd_bus_arbiter
module tb_lcd_bus_arbiter;
  localparam int PIX_DEPTH = 4;
  localparam int WR_GAP    = 1;

  logic       clk = 1'b0;
  logic       reset;
  logic       pix_valid;
  logic [7:0] pix_data;
  logic       cmd_valid;
  logic [7:0] cmd_data;
  logic       cmd_cd;
  logic       cmd_last;
  logic       cmd_ready;
  logic [7:0] lcd_data;
  logic       lcd_cd;
  logic       lcd_write;
  logic       pix_ovf;
  logic       busy;

  int n_vec  = 0;
  int n_fail = 0;
  logic [8:0] exp_q [$];
  logic       prev_wr = 1'b0;

  lcd_bus_arbiter #(.PIX_DEPTH(PIX_DEPTH), .WR_GAP(WR_GAP)) dut (
    .clk       (clk),
    .reset     (reset),
    .pix_valid (pix_valid),
    .pix_data  (pix_data),
    .cmd_valid (cmd_valid),
    .cmd_data  (cmd_data),
    .cmd_cd    (cmd_cd),
    .cmd_last  (cmd_last),
    .cmd_ready (cmd_ready),
    .lcd_data  (lcd_data),
    .lcd_cd    (lcd_cd),
    .lcd_write (lcd_write),
    .pix_ovf   (pix_ovf),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_vec++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic look();
    #2;
  endtask

  // Every bus strobe must match the next queued byte in order.
  always @(negedge clk) begin
    if (!reset && lcd_write) begin
      chk("strobe_width", 32'(prev_wr), 32'(1'b0));
      if (exp_q.size() == 0) begin
        chk("sb_underflow", 32'(exp_q.size()), 32'd1);
      end else begin
        chk("bus_byte", 32'({lcd_cd, lcd_data}), 32'(exp_q.pop_front()));
      end
    end
    prev_wr = lcd_write & ~reset;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    pix_valid = 1'b0; pix_data = 8'h00;
    cmd_valid = 1'b0; cmd_data = 8'h00; cmd_cd = 1'b0; cmd_last = 1'b0;
    tick(); tick();
    reset = 1'b0;
    look();
    chk("rst_lcd_data", 32'(lcd_data), 32'h0);
    chk("rst_lcd_cd", 32'(lcd_cd), 32'h0);
    chk("rst_lcd_write", 32'(lcd_write), 32'h0);
    chk("rst_cmd_ready", 32'(cmd_ready), 32'h0);
    chk("rst_pix_ovf", 32'(pix_ovf), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);

    // single pixel latency
    tick(); pix_valid = 1'b1; pix_data = 8'h5A; exp_q.push_back({1'b1, 8'h5A});
    look(); chk("t1_wr_t0", 32'(lcd_write), 32'h0);
    tick(); pix_valid = 1'b0;
    look(); chk("t1_wr_t1", 32'(lcd_write), 32'h0);
    tick(); look(); chk("t1_strobe", 32'({lcd_write, lcd_cd, lcd_data}), 32'({1'b1, 1'b1, 8'h5A}));
    tick(); look(); chk("t1_busy_gap", 32'(busy), 32'h1);
    tick(); look(); chk("t1_busy_idle", 32'(busy), 32'h0);

    // pixel stream every second cycle
    for (int i = 0; i < 8; i++) begin
      tick(); pix_valid = 1'b1; pix_data = 8'(i + 1); exp_q.push_back({1'b1, 8'(i + 1)});
      look();
      if (i > 0) chk("t2_strobe", 32'({lcd_write, lcd_data}), 32'({1'b1, 8'(i)}));
      tick(); pix_valid = 1'b0;
      look(); chk("t2_gap", 32'(lcd_write), 32'h0);
    end
    tick(); look(); chk("t2_last", 32'({lcd_write, lcd_data}), 32'({1'b1, 8'h08}));
    chk("t2_ovf", 32'(pix_ovf), 32'h0);
    repeat (3) tick();

    // atomic two-byte command with pixels injected
    tick(); cmd_valid = 1'b1; cmd_data = 8'h81; cmd_cd = 1'b0; cmd_last = 1'b0;
    exp_q.push_back({1'b0, 8'h81});
    look(); chk("t3_ready1", 32'(cmd_ready), 32'h1);
    tick(); cmd_valid = 1'b0; pix_valid = 1'b1; pix_data = 8'hA0;
    exp_q.push_back({1'b1, 8'h20}); exp_q.push_back({1'b1, 8'hA0});
    look(); chk("t3_strobe81", 32'({lcd_write, lcd_cd, lcd_data}), 32'({1'b1, 1'b0, 8'h81}));
    tick(); pix_data = 8'hA1; exp_q.push_back({1'b1, 8'hA1});
    look(); chk("t3_locked_busy", 32'(busy), 32'h1);
    tick(); pix_valid = 1'b0; cmd_valid = 1'b1; cmd_data = 8'h20; cmd_cd = 1'b1; cmd_last = 1'b1;
    look(); chk("t3_ready2", 32'(cmd_ready), 32'h1);
    chk("t3_no_pix_in_lock", 32'(lcd_write), 32'h0);
    tick(); cmd_valid = 1'b0;
    look(); chk("t3_strobe20", 32'({lcd_write, lcd_data}), 32'({1'b1, 8'h20}));
    repeat (6) tick();
    chk("t3_drained", 32'(exp_q.size()), 32'd0);

    // overflow while locked
    tick(); cmd_valid = 1'b1; cmd_data = 8'h2C; cmd_cd = 1'b0; cmd_last = 1'b0;
    exp_q.push_back({1'b0, 8'h2C}); exp_q.push_back({1'b1, 8'h00});
    look(); chk("t4_ready1", 32'(cmd_ready), 32'h1);
    for (int k = 0; k <= PIX_DEPTH; k++) begin
      tick(); cmd_valid = 1'b0; pix_valid = 1'b1; pix_data = 8'(8'hB0 + k);
      if (k < PIX_DEPTH) exp_q.push_back({1'b1, 8'(8'hB0 + k)});
      look(); chk("t4_no_ovf_yet", 32'(pix_ovf), 32'h0);
    end
    tick(); pix_valid = 1'b0; cmd_valid = 1'b1; cmd_data = 8'h00; cmd_cd = 1'b1; cmd_last = 1'b1;
    look(); chk("t4_ovf_set", 32'(pix_ovf), 32'h1);
    chk("t4_ready2", 32'(cmd_ready), 32'h1);
    tick(); cmd_valid = 1'b0;
    repeat (12) tick();
    chk("t4_drained", 32'(exp_q.size()), 32'd0);
    chk("t4_ovf_sticky", 32'(pix_ovf), 32'h1);

    // FIFO drains before a waiting command
    tick(); pix_valid = 1'b1; pix_data = 8'hC0; exp_q.push_back({1'b1, 8'hC0});
    tick(); pix_data = 8'hC1; exp_q.push_back({1'b1, 8'hC1});
    cmd_valid = 1'b1; cmd_data = 8'h11; cmd_cd = 1'b0; cmd_last = 1'b1;
    look(); chk("t5_ready_c1", 32'(cmd_ready), 32'h0);
    tick(); pix_data = 8'hC2; exp_q.push_back({1'b1, 8'hC2}); exp_q.push_back({1'b0, 8'h11});
    look(); chk("t5_ready_c2", 32'(cmd_ready), 32'h0);
    for (int k = 3; k <= 7; k++) begin
      tick(); pix_valid = 1'b0;
      look(); chk("t5_ready", 32'(cmd_ready), 32'(k == 7));
    end
    tick(); cmd_valid = 1'b0;
    look(); chk("t5_cmd_strobe", 32'({lcd_write, lcd_cd, lcd_data}), 32'({1'b1, 1'b0, 8'h11}));
    repeat (3) tick();

    // simultaneous pixel and command on empty FIFO: command first
    tick(); pix_valid = 1'b1; pix_data = 8'hD0;
    cmd_valid = 1'b1; cmd_data = 8'h33; cmd_cd = 1'b0; cmd_last = 1'b1;
    exp_q.push_back({1'b0, 8'h33}); exp_q.push_back({1'b1, 8'hD0});
    look(); chk("t5b_ready", 32'(cmd_ready), 32'h1);
    tick(); pix_valid = 1'b0; cmd_valid = 1'b0;
    look(); chk("t5b_cmd", 32'({lcd_write, lcd_data}), 32'({1'b1, 8'h33}));
    tick(); tick();
    look(); chk("t5b_pix", 32'({lcd_write, lcd_cd, lcd_data}), 32'({1'b1, 1'b1, 8'hD0}));
    repeat (3) tick();

    // reset during a locked sequence with buffered pixels
    tick(); cmd_valid = 1'b1; cmd_data = 8'h40; cmd_cd = 1'b0; cmd_last = 1'b0;
    exp_q.push_back({1'b0, 8'h40});
    look(); chk("t6_ready", 32'(cmd_ready), 32'h1);
    for (int k = 0; k < 3; k++) begin
      tick(); cmd_valid = 1'b0; pix_valid = 1'b1; pix_data = 8'(8'hE8 + k);
    end
    tick(); pix_valid = 1'b0; reset = 1'b1;
    tick(); reset = 1'b0;
    look(); chk("t6_outs_zero", 32'({lcd_data, lcd_cd, lcd_write, cmd_ready, pix_ovf, busy}), 32'h0);
    tick(); pix_valid = 1'b1; pix_data = 8'h77; exp_q.push_back({1'b1, 8'h77});
    look(); chk("t6_wr0", 32'(lcd_write), 32'h0);
    tick(); pix_valid = 1'b0;
    look(); chk("t6_wr1", 32'(lcd_write), 32'h0);
    tick(); look(); chk("t6_strobe", 32'({lcd_write, lcd_cd, lcd_data}), 32'({1'b1, 1'b1, 8'h77}));
    repeat (3) tick();

    // push and pop on a full FIFO loses nothing
    tick(); cmd_valid = 1'b1; cmd_data = 8'hF1; cmd_cd = 1'b0; cmd_last = 1'b0;
    exp_q.push_back({1'b0, 8'hF1}); exp_q.push_back({1'b1, 8'hF2});
    for (int k = 0; k < PIX_DEPTH; k++) begin
      tick(); cmd_valid = 1'b0; pix_valid = 1'b1; pix_data = 8'(8'hE0 + k);
      exp_q.push_back({1'b1, 8'(8'hE0 + k)});
    end
    tick(); pix_valid = 1'b0; cmd_valid = 1'b1; cmd_data = 8'hF2; cmd_cd = 1'b1; cmd_last = 1'b1;
    look(); chk("t7_ready", 32'(cmd_ready), 32'h1);
    tick(); cmd_valid = 1'b0;
    tick(); pix_valid = 1'b1; pix_data = 8'hE4; exp_q.push_back({1'b1, 8'hE4});
    tick(); pix_valid = 1'b0;
    look(); chk("t7_no_ovf", 32'(pix_ovf), 32'h0);
    repeat (12) tick();
    chk("t7_drained", 32'(exp_q.size()), 32'd0);
    chk("t7_ovf_final", 32'(pix_ovf), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end
endmodule
